// File: rtl/fir_seq_ctrl.sv
// Run sequencer for the 32-tap symmetric FIR: streams one block of input samples,
// keeps the pipeline fed with zeros while it drains, and stores the outputs.
module fir_seq_ctrl #(
    parameter int N_SAMPLES = 1024,
    parameter int ADDR_W    = 10,
    parameter int FLUSH_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [15:0]       in_rd_data,
    output logic              fir_data_valid,
    output logic [15:0]       fir_data,
    input  logic              fir_valid,
    input  logic [15:0]       fir_d,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [15:0]       out_wr_data,
    output logic [ADDR_W:0]   out_count
);

    localparam int RD_W = $clog2(N_SAMPLES + 1);
    localparam int FL_W = $clog2(FLUSH_MAX + 1);
    localparam logic [RD_W-1:0]   RD_LAST  = RD_W'(N_SAMPLES - 1);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(FLUSH_MAX - 1);
    localparam logic [ADDR_W:0]   OUT_FULL = (ADDR_W + 1)'(N_SAMPLES);
    localparam logic [ADDR_W:0]   OUT_LAST = (ADDR_W + 1)'(N_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t            state_reg, state_next;
    logic [RD_W-1:0]   rd_cnt_reg;
    logic [FL_W-1:0]   flush_cnt_reg;
    logic [ADDR_W:0]   out_count_reg;
    logic              err_reg;
    logic              rd_en_d_reg;
    logic              flush_d_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [15:0]       wr_data_reg;

    logic running, capture, last_capture, timeout;

    always_comb begin
        running      = (state_reg == STREAM) || (state_reg == FLUSH);
        capture      = running && !abort && fir_valid && (out_count_reg < OUT_FULL);
        last_capture = capture && (out_count_reg == OUT_LAST);
        // Completing the last capture on the final flush cycle is a success, not a timeout.
        timeout      = (state_reg == FLUSH) && !abort && !last_capture && (flush_cnt_reg == FL_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = STREAM;
            STREAM: begin
                if (abort)                       state_next = IDLE;
                else if (last_capture)           state_next = DONE;
                else if (rd_cnt_reg == RD_LAST)  state_next = FLUSH;
            end
            FLUSH: begin
                if (abort)                       state_next = IDLE;
                else if (last_capture || timeout) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_reg    <= '0;
            flush_cnt_reg <= '0;
            out_count_reg <= '0;
            err_reg       <= 1'b0;
            rd_en_d_reg   <= 1'b0;
            flush_d_reg   <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            rd_en_d_reg <= (state_reg == STREAM);
            flush_d_reg <= (state_reg == FLUSH);
            wr_en_reg   <= capture;
            if (state_reg == IDLE && start) begin
                rd_cnt_reg    <= '0;
                flush_cnt_reg <= '0;
                out_count_reg <= '0;
                err_reg       <= 1'b0;
            end
            if (state_reg == STREAM) rd_cnt_reg <= rd_cnt_reg + RD_W'(1);
            if (state_reg == FLUSH)  flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
            if (timeout) err_reg <= 1'b1;
            if (capture) begin
                wr_addr_reg   <= out_count_reg[ADDR_W-1:0];
                wr_data_reg   <= fir_d;
                out_count_reg <= out_count_reg + (ADDR_W + 1)'(1);
            end
        end
    end

    // Feed valid is masked outside STREAM/FLUSH so it drops the cycle DONE or an abort lands.
    always_comb begin
        busy           = running;
        done           = (state_reg == DONE);
        err            = err_reg;
        in_rd_en       = (state_reg == STREAM);
        in_rd_addr     = '0;
        if (state_reg == STREAM) in_rd_addr = ADDR_W'(rd_cnt_reg);
        fir_data_valid = running && (rd_en_d_reg || flush_d_reg);
        fir_data       = '0;
        if (fir_data_valid && rd_en_d_reg) fir_data = in_rd_data;
        out_wr_en      = wr_en_reg;
        out_wr_addr    = wr_addr_reg;
        out_wr_data    = wr_data_reg;
        out_count      = out_count_reg;
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: two sequencers (64- and 8-sample blocks) driven against
// a delay-line FIR model, memory models and a per-run transaction log.
module tb_fir_seq_ctrl;

    localparam int LAT = 37;
    localparam int AW  = 6;
    localparam int LOG = 128;

    function automatic int ns(input int i);
        return (i == 0) ? 64 : 8;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    start, abort;
    logic [1:0]    busy, done, err, in_rd_en, fir_data_valid, fir_valid, out_wr_en;
    logic [AW-1:0] in_rd_addr [2];
    logic [AW-1:0] out_wr_addr [2];
    logic [15:0]   in_rd_data [2];
    logic [15:0]   fir_data [2];
    logic [15:0]   fir_d [2];
    logic [15:0]   out_wr_data [2];
    logic [AW:0]   out_count [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            fir_seq_ctrl #(
                .N_SAMPLES ((gi == 0) ? 64 : 8),
                .ADDR_W    (AW),
                .FLUSH_MAX (64)
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .start          (start[gi]),
                .abort          (abort[gi]),
                .busy           (busy[gi]),
                .done           (done[gi]),
                .err            (err[gi]),
                .in_rd_en       (in_rd_en[gi]),
                .in_rd_addr     (in_rd_addr[gi]),
                .in_rd_data     (in_rd_data[gi]),
                .fir_data_valid (fir_data_valid[gi]),
                .fir_data       (fir_data[gi]),
                .fir_valid      (fir_valid[gi]),
                .fir_d          (fir_d[gi]),
                .out_wr_en      (out_wr_en[gi]),
                .out_wr_addr    (out_wr_addr[gi]),
                .out_wr_data    (out_wr_data[gi]),
                .out_count      (out_count[gi])
            );
        end
    endgenerate

    // Input memory and FIR model: output k is feed word k, valid once LAT+1 gapless feeds have gone in.
    logic [15:0] in_mem [2][64];
    logic [15:0] hist [2][256];
    int          vcnt [2];
    logic [1:0]  fir_mute;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (in_rd_en[i]) in_rd_data[i] <= in_mem[i][in_rd_addr[i]];
            if (fir_data_valid[i]) begin
                hist[i][vcnt[i] % 256] <= fir_data[i];
                vcnt[i]      <= vcnt[i] + 1;
                fir_valid[i] <= !fir_mute[i] && (vcnt[i] >= LAT);
                fir_d[i]     <= (vcnt[i] >= LAT) ? hist[i][(vcnt[i] - LAT) % 256] : 16'h0;
            end else begin
                vcnt[i]      <= 0;
                fir_valid[i] <= 1'b0;
                fir_d[i]     <= 16'h0;
            end
        end
    end

    // Transaction log, sampled mid-cycle.
    logic [1:0]    clr;
    logic [AW-1:0] rd_log [2][LOG];
    logic [AW-1:0] wa_log [2][LOG];
    logic [15:0]   wd_log [2][LOG];
    int            rd_n [2], wr_n [2], done_n [2], dv_n [2], dv_rise [2], nz_n [2], ovl_n [2];
    bit [1:0]      dv_prev;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr[i]) begin
                rd_n[i] <= 0; wr_n[i] <= 0; done_n[i] <= 0; dv_n[i] <= 0;
                dv_rise[i] <= 0; nz_n[i] <= 0; ovl_n[i] <= 0; dv_prev[i] <= 1'b0;
            end else begin
                if (in_rd_en[i] === 1'b1) begin
                    if (rd_n[i] < LOG) rd_log[i][rd_n[i]] <= in_rd_addr[i];
                    rd_n[i] <= rd_n[i] + 1;
                end
                if (out_wr_en[i] === 1'b1) begin
                    if (wr_n[i] < LOG) begin
                        wa_log[i][wr_n[i]] <= out_wr_addr[i];
                        wd_log[i][wr_n[i]] <= out_wr_data[i];
                    end
                    wr_n[i] <= wr_n[i] + 1;
                    if (in_rd_en[i] === 1'b1) ovl_n[i] <= ovl_n[i] + 1;
                end
                if (done[i] === 1'b1) done_n[i] <= done_n[i] + 1;
                if (fir_data_valid[i] === 1'b1) begin
                    dv_n[i] <= dv_n[i] + 1;
                    if (dv_n[i] >= ns(i) && fir_data[i] !== 16'h0) nz_n[i] <= nz_n[i] + 1;
                    if (!dv_prev[i]) dv_rise[i] <= dv_rise[i] + 1;
                end
                dv_prev[i] <= (fir_data_valid[i] === 1'b1);
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        clr = 2'b11;
        tick(1);
        clr = 2'b00;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    task automatic fill_mem(input int i);
        for (int k = 0; k < 64; k++) in_mem[i][k] = 16'($urandom);
    endtask

    task automatic wait_done(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (done[i] === 1'b1) ok = 1'b1;
        end
        tick(2);
        $display("run dut%0d: reads=%0d writes=%0d done_pulses=%0d err=%b out_count=%0d feed=%0d",
                 i, rd_n[i], wr_n[i], done_n[i], err[i], out_count[i], dv_n[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total++;
        if ({busy, done, err, in_rd_en, fir_data_valid, out_wr_en} !== 12'h0)
            $display("FAIL reset_ctrl got %h want 000", {busy, done, err, in_rd_en, fir_data_valid, out_wr_en});
        else passed++;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({out_count[i], in_rd_addr[i], out_wr_addr[i], out_wr_data[i], fir_data[i]} !== '0)
                $display("FAIL reset_data dut%0d got cnt=%0d ra=%0d wa=%0d wd=%h fd=%h want all 0", i,
                         out_count[i], in_rd_addr[i], out_wr_addr[i], out_wr_data[i], fir_data[i]);
            else passed++;
        end
        rst = 1'b0;
        tick(3);
        total++;
        if (busy !== 2'b00 || in_rd_en !== 2'b00 || done !== 2'b00)
            $display("FAIL reset_idle got busy=%b rd_en=%b done=%b want 00/00/00", busy, in_rd_en, done);
        else passed++;
    endtask

    task automatic test_stream();
        bit ok;
        int rbad, wbad;
        for (int k = 0; k < 64; k++) in_mem[0][k] = 16'(k);
        clear_logs();
        pulse_start(0);
        @(negedge clk);
        total++;
        if (!(in_rd_en[0] === 1'b1 && in_rd_addr[0] === '0 && busy[0] === 1'b1 && fir_data_valid[0] === 1'b0))
            $display("FAIL t1_first_read got en=%b addr=%0d busy=%b dv=%b want 1/0/1/0",
                     in_rd_en[0], in_rd_addr[0], busy[0], fir_data_valid[0]);
        else passed++;
        wait_done(0, 400, ok);
        total++; if (!ok) $display("FAIL t1_done got none want pulse within 400 cycles"); else passed++;
        rbad = 0; wbad = 0;
        for (int k = 0; k < 64; k++) begin
            if (rd_log[0][k] !== AW'(k)) rbad++;
            if (wa_log[0][k] !== AW'(k) || wd_log[0][k] !== in_mem[0][k]) wbad++;
        end
        total++; if (rd_n[0] !== 64) $display("FAIL t1_reads got %0d want 64", rd_n[0]); else passed++;
        total++; if (rbad !== 0) $display("FAIL t1_read_order got %0d bad want 0", rbad); else passed++;
        total++; if (wr_n[0] !== 64) $display("FAIL t1_writes got %0d want 64", wr_n[0]); else passed++;
        total++; if (wbad !== 0) $display("FAIL t1_write_data got %0d bad want 0", wbad); else passed++;
        total++; if (done_n[0] !== 1) $display("FAIL t1_done_count got %0d want 1", done_n[0]); else passed++;
        total++; if (err[0] !== 1'b0) $display("FAIL t1_err got %b want 0", err[0]); else passed++;
        total++; if (out_count[0] !== 7'd64) $display("FAIL t1_out_count got %0d want 64", out_count[0]); else passed++;
        total++; if (dv_n[0] !== 64 + LAT + 1) $display("FAIL t1_feed_len got %0d want %0d", dv_n[0], 64 + LAT + 1); else passed++;
        total++; if (dv_rise[0] !== 1) $display("FAIL t1_feed_gaps got %0d bursts want 1", dv_rise[0]); else passed++;
        total++; if (nz_n[0] !== 0) $display("FAIL t1_zero_feed got %0d nonzero want 0", nz_n[0]); else passed++;
    endtask

    task automatic test_short_block();
        bit ok;
        int wbad;
        fill_mem(1);
        clear_logs();
        pulse_start(1);
        wait_done(1, 300, ok);
        total++; if (!ok) $display("FAIL t2_done got none want pulse within 300 cycles"); else passed++;
        wbad = 0;
        for (int k = 0; k < 8; k++)
            if (wa_log[1][k] !== AW'(k) || wd_log[1][k] !== in_mem[1][k] || rd_log[1][k] !== AW'(k)) wbad++;
        total++; if (rd_n[1] !== 8 || wr_n[1] !== 8) $display("FAIL t2_counts got rd=%0d wr=%0d want 8/8", rd_n[1], wr_n[1]); else passed++;
        total++; if (wbad !== 0) $display("FAIL t2_data got %0d bad want 0", wbad); else passed++;
        total++; if (ovl_n[1] !== 0) $display("FAIL t2_write_in_stream got %0d want 0", ovl_n[1]); else passed++;
        total++; if (dv_n[1] !== 8 + LAT + 1) $display("FAIL t2_feed_len got %0d want %0d", dv_n[1], 8 + LAT + 1); else passed++;
        total++; if (out_count[1] !== 7'd8 || done_n[1] !== 1 || err[1] !== 1'b0)
            $display("FAIL t2_status got cnt=%0d done=%0d err=%b want 8/1/0", out_count[1], done_n[1], err[1]);
        else passed++;
    endtask

    task automatic test_timeout();
        bit ok;
        fill_mem(0);
        fir_mute[0] = 1'b1;
        clear_logs();
        pulse_start(0);
        wait_done(0, 400, ok);
        total++; if (!ok) $display("FAIL t3_done got none want pulse within 400 cycles"); else passed++;
        total++; if (err[0] !== 1'b1) $display("FAIL t3_err got %b want 1", err[0]); else passed++;
        total++; if (out_count[0] !== '0 || wr_n[0] !== 0)
            $display("FAIL t3_no_writes got cnt=%0d wr=%0d want 0/0", out_count[0], wr_n[0]);
        else passed++;
        total++; if (done_n[0] !== 1 || rd_n[0] !== 64)
            $display("FAIL t3_run got done=%0d rd=%0d want 1/64", done_n[0], rd_n[0]);
        else passed++;
        fir_mute[0] = 1'b0;
        clear_logs();
        pulse_start(0);
        @(negedge clk);
        total++; if (err[0] !== 1'b0 || busy[0] !== 1'b1) $display("FAIL t3_err_clear got err=%b busy=%b want 0/1", err[0], busy[0]); else passed++;
        wait_done(0, 400, ok);
        total++; if (!ok || wr_n[0] !== 64 || err[0] !== 1'b0)
            $display("FAIL t3_rerun got done=%b wr=%0d err=%b want 1/64/0", ok, wr_n[0], err[0]);
        else passed++;
    endtask

    task automatic test_abort();
        bit ok;
        int k, rbad;
        fill_mem(0);
        k = $urandom_range(5, 30);
        clear_logs();
        pulse_start(0);
        tick(k - 1);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        @(negedge clk);
        total++;
        if ({in_rd_en[0], fir_data_valid[0], busy[0], out_wr_en[0]} !== 4'b0000)
            $display("FAIL t4_abort_stop got en=%b dv=%b busy=%b wr=%b want 0000",
                     in_rd_en[0], fir_data_valid[0], busy[0], out_wr_en[0]);
        else passed++;
        tick(100);
        rbad = 0;
        for (int a = 0; a < k; a++) if (rd_log[0][a] !== AW'(a)) rbad++;
        total++; if (rd_n[0] !== k || rbad !== 0) $display("FAIL t4_partial_reads got %0d (%0d bad) want %0d", rd_n[0], rbad, k); else passed++;
        total++; if (done_n[0] !== 0 || out_count[0] !== '0)
            $display("FAIL t4_no_done got done=%0d cnt=%0d want 0/0", done_n[0], out_count[0]);
        else passed++;
        clear_logs();
        pulse_start(0);
        wait_done(0, 400, ok);
        rbad = 0;
        for (int a = 0; a < 64; a++)
            if (rd_log[0][a] !== AW'(a) || wa_log[0][a] !== AW'(a) || wd_log[0][a] !== in_mem[0][a]) rbad++;
        total++; if (!ok || rd_n[0] !== 64 || wr_n[0] !== 64 || rbad !== 0)
            $display("FAIL t4_rerun got done=%b rd=%0d wr=%0d bad=%0d want 1/64/64/0", ok, rd_n[0], wr_n[0], rbad);
        else passed++;
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int rbad;
        fill_mem(0);
        clear_logs();
        pulse_start(0);
        for (int r = 0; r < 10; r++) begin
            tick($urandom_range(1, 6));
            pulse_start(0);
        end
        wait_done(0, 400, ok);
        tick(30);
        rbad = 0;
        for (int a = 0; a < 64; a++)
            if (rd_log[0][a] !== AW'(a) || wd_log[0][a] !== in_mem[0][a]) rbad++;
        total++; if (!ok || rd_n[0] !== 64 || rbad !== 0)
            $display("FAIL t5_reads got done=%b rd=%0d bad=%0d want 1/64/0", ok, rd_n[0], rbad);
        else passed++;
        total++; if (done_n[0] !== 1 || wr_n[0] !== 64 || busy[0] !== 1'b0)
            $display("FAIL t5_single_run got done=%0d wr=%0d busy=%b want 1/64/0", done_n[0], wr_n[0], busy[0]);
        else passed++;
    endtask

    task automatic test_reset_mid_flush();
        bit ok;
        int w, rbad;
        fill_mem(0);
        clear_logs();
        pulse_start(0);
        tick(75);
        total++; if (busy[0] !== 1'b1 || in_rd_en[0] !== 1'b0) $display("FAIL t6_in_flush got busy=%b rd_en=%b want 1/0", busy[0], in_rd_en[0]); else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({busy[0], done[0], err[0], in_rd_en[0], fir_data_valid[0], out_wr_en[0], out_count[0],
             in_rd_addr[0], out_wr_addr[0], out_wr_data[0], fir_data[0]} !== '0)
            $display("FAIL t6_async_clear got busy=%b dv=%b wr=%b cnt=%0d wd=%h want all 0",
                     busy[0], fir_data_valid[0], out_wr_en[0], out_count[0], out_wr_data[0]);
        else passed++;
        w = wr_n[0];
        tick(4);
        total++; if (wr_n[0] !== w) $display("FAIL t6_no_write_in_reset got %0d want %0d", wr_n[0], w); else passed++;
        rst = 1'b0;
        tick(5);
        total++; if (busy[0] !== 1'b0 || in_rd_en[0] !== 1'b0) $display("FAIL t6_idle got busy=%b rd_en=%b want 0/0", busy[0], in_rd_en[0]); else passed++;
        clear_logs();
        pulse_start(0);
        wait_done(0, 400, ok);
        rbad = 0;
        for (int a = 0; a < 64; a++)
            if (rd_log[0][a] !== AW'(a) || wa_log[0][a] !== AW'(a) || wd_log[0][a] !== in_mem[0][a]) rbad++;
        total++; if (!ok || wr_n[0] !== 64 || rbad !== 0 || out_count[0] !== 7'd64)
            $display("FAIL t6_rerun got done=%b wr=%0d bad=%0d cnt=%0d want 1/64/0/64", ok, wr_n[0], rbad, out_count[0]);
        else passed++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 2'b00;
        abort    = 2'b00;
        fir_mute = 2'b00;
        clr      = 2'b11;
        test_reset();
        clr = 2'b00;
        test_stream();
        test_short_block();
        test_timeout();
        test_abort();
        test_start_while_busy();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
